// File: rtl/spi_master_gen_if.sv
// Handshake/bus bundle between the controlling device and spi_master_gen.
// The controlling device uses the master modport; the SPI engine uses slave.
interface spi_master_gen_if #(
  parameter int DATA_W   = 8,
  parameter int CS_SEL_W = 1
);
  logic                p_start;
  logic                p_cpol;
  logic                p_cpha;
  logic [CS_SEL_W-1:0] p_cs_sel;
  logic [DATA_W-1:0]   p_data_in;
  logic [DATA_W-1:0]   p_data_out;
  logic                p_busy;
  logic                p_done;
  logic                p_err;

  modport master (
    output p_start, p_cpol, p_cpha, p_cs_sel, p_data_in,
    input  p_data_out, p_busy, p_done, p_err
  );

  modport slave (
    input  p_start, p_cpol, p_cpha, p_cs_sel, p_data_in,
    output p_data_out, p_busy, p_done, p_err
  );
endinterface

// File: rtl/spi_master_gen.sv
// Clocked SPI master: divider-generated SCK, run-time CPOL/CPHA, DATA_W-bit
// full-duplex word to one of NUM_CS slaves, start/busy/done handshake.
// Sequence per transfer: SETUP (CS low, SCK idle), XFER (2*DATA_W SCK
// half-periods), HOLD (SCK idle, CS low), then back to IDLE with p_done.
module spi_master_gen #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int NUM_CS    = 1,
  parameter int MSB_FIRST = 1,
  parameter int CS_SEL_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_gen_if.slave   p_if,
  output logic              sck,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [NUM_CS-1:0] CS_ONE = NUM_CS'(1'b1);
  localparam logic [NUM_CS-1:0] CS_ALL = {NUM_CS{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_XFER  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic                cpol_q;
  logic                cpha_q;
  logic [DATA_W-1:0]   tx_q;
  logic [DATA_W-1:0]   rx_q;
  logic                sck_q;
  logic [NUM_CS-1:0]   cs_n_q;
  logic                mosi_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [DATA_W-1:0]   data_out_q;

  logic [DIV_W-1:0]    div_d;
  logic                div_end_s;
  logic                lead_half_s;
  logic                last_bit_s;
  logic                all_bits_s;
  logic [BIT_W-1:0]    bit_nxt_s;
  logic [CS_SEL_W-1:0] sel_s;
  logic                sel_ok_s;

  // Wire position of logical bit number b (0 = first bit on the wire).
  function automatic logic [IDX_W-1:0] pos_f(input logic [BIT_W-1:0] b);
    if (MSB_FIRST != 0) begin
      pos_f = IDX_W'(DATA_W - 1) - IDX_W'(b);
    end else begin
      pos_f = IDX_W'(b);
    end
  endfunction

  // Divider wrap, half-period phase and bit-count decodes.
  always_comb begin
    div_end_s   = (div_q == DIV_W'(CLK_DIV - 1));
    div_d       = div_end_s ? {DIV_W{1'b0}} : (div_q + DIV_W'(1'b1));
    lead_half_s = (sck_q != cpol_q);
    last_bit_s  = (bit_q == BIT_W'(DATA_W - 1));
    all_bits_s  = (bit_q == BIT_W'(DATA_W));
    bit_nxt_s   = bit_q + BIT_W'(1'b1);
    sel_s       = p_if.p_cs_sel;
    sel_ok_s    = (32'(sel_s) < 32'(NUM_CS));
  end

  // Transfer FSM with registered pin and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= {DIV_W{1'b0}};
      bit_q      <= {BIT_W{1'b0}};
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      tx_q       <= {DATA_W{1'b0}};
      rx_q       <= {DATA_W{1'b0}};
      sck_q      <= 1'b0;
      cs_n_q     <= CS_ALL;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= {DATA_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          div_q <= {DIV_W{1'b0}};
          bit_q <= {BIT_W{1'b0}};
          if (p_if.p_start) begin
            if (sel_ok_s) begin
              state_q <= S_SETUP;
              cpol_q  <= p_if.p_cpol;
              cpha_q  <= p_if.p_cpha;
              tx_q    <= p_if.p_data_in;
              rx_q    <= {DATA_W{1'b0}};
              sck_q   <= p_if.p_cpol;
              cs_n_q  <= ~(CS_ONE << sel_s);
              busy_q  <= 1'b1;
              // CPHA=0 slaves sample on the very first edge, so bit 0 must
              // already be on the wire during SETUP.
              mosi_q  <= p_if.p_cpha ? 1'b0 : p_if.p_data_in[pos_f({BIT_W{1'b0}})];
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          div_q <= div_d;
          if (div_end_s) begin
            state_q <= S_XFER;
            bit_q   <= {BIT_W{1'b0}};
            sck_q   <= ~cpol_q;
            if (cpha_q) begin
              mosi_q <= tx_q[pos_f(bit_q)];
            end else begin
              rx_q[pos_f(bit_q)] <= miso;
            end
          end
        end
        S_XFER: begin
          div_q <= div_d;
          if (div_end_s) begin
            if (lead_half_s) begin
              // Trailing edge closes one bit.
              sck_q <= cpol_q;
              bit_q <= bit_nxt_s;
              if (cpha_q) begin
                rx_q[pos_f(bit_q)] <= miso;
              end else if (!last_bit_s) begin
                mosi_q <= tx_q[pos_f(bit_nxt_s)];
              end
            end else if (all_bits_s) begin
              state_q <= S_HOLD;
            end else begin
              // Leading edge opens the next bit.
              sck_q <= ~cpol_q;
              if (cpha_q) begin
                mosi_q <= tx_q[pos_f(bit_q)];
              end else begin
                rx_q[pos_f(bit_q)] <= miso;
              end
            end
          end
        end
        S_HOLD: begin
          div_q <= div_d;
          if (div_end_s) begin
            state_q    <= S_IDLE;
            cs_n_q     <= CS_ALL;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            data_out_q <= rx_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= CS_ALL;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sck             = sck_q;
  assign cs_n            = cs_n_q;
  assign mosi            = mosi_q;
  assign p_if.p_busy     = busy_q;
  assign p_if.p_done     = done_q;
  assign p_if.p_err      = err_q;
  assign p_if.p_data_out = data_out_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: two instances (8-bit/div2/4 CS/MSB-first and
// 16-bit/div1/1 CS/LSB-first) observed through one muxed view, an SPI slave
// model reacting to SCK/CS edges, and a cycle monitor counting edge events.
module tb_spi_master_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned dsel;
  logic        start_b, cpol_b, cpha_b;
  logic [2:0]  sel_b;
  logic [15:0] din_b;

  spi_master_gen_if #(.DATA_W(8),  .CS_SEL_W(3)) ifa ();
  spi_master_gen_if #(.DATA_W(16), .CS_SEL_W(1)) ifb ();

  assign ifa.p_start   = start_b && (dsel == 0);
  assign ifa.p_cpol    = cpol_b;
  assign ifa.p_cpha    = cpha_b;
  assign ifa.p_cs_sel  = sel_b;
  assign ifa.p_data_in = din_b[7:0];
  assign ifb.p_start   = start_b && (dsel == 1);
  assign ifb.p_cpol    = cpol_b;
  assign ifb.p_cpha    = cpha_b;
  assign ifb.p_cs_sel  = sel_b[0];
  assign ifb.p_data_in = din_b;

  logic       sck_a, mosi_a, sck_b, mosi_b, miso_s;
  logic [3:0] cs_n_a;
  logic [0:0] cs_n_b;

  spi_master_gen #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4), .MSB_FIRST(1), .CS_SEL_W(3)) dut_a (
    .clk(clk), .rst(rst), .p_if(ifa), .sck(sck_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_s));
  spi_master_gen #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(1), .MSB_FIRST(0), .CS_SEL_W(1)) dut_b (
    .clk(clk), .rst(rst), .p_if(ifb), .sck(sck_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_s));

  // muxed view of the selected instance
  logic        sck_m, mosi_m, busy_m, done_m, err_m, cs_act, msb_m;
  logic [3:0]  cs_m;
  logic [15:0] dout_m;
  int          w_m, div_m;
  assign sck_m  = (dsel == 1) ? sck_b : sck_a;
  assign mosi_m = (dsel == 1) ? mosi_b : mosi_a;
  assign busy_m = (dsel == 1) ? ifb.p_busy : ifa.p_busy;
  assign done_m = (dsel == 1) ? ifb.p_done : ifa.p_done;
  assign err_m  = (dsel == 1) ? ifb.p_err : ifa.p_err;
  assign cs_m   = (dsel == 1) ? {3'b111, cs_n_b} : cs_n_a;
  assign dout_m = (dsel == 1) ? ifb.p_data_out : {8'h00, ifa.p_data_out};
  assign w_m    = (dsel == 1) ? 16 : 8;
  assign div_m  = (dsel == 1) ? 1 : 2;
  assign msb_m  = (dsel == 0);
  assign cs_act = (cs_m != 4'hF);

  // expectations for the transfer in flight
  logic        t_cpol = 1'b0, t_cpha = 1'b0, loop_b = 1'b1;
  logic [3:0]  exp_cs = 4'hF;
  logic [15:0] sl_word = 16'h0000;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int bpos(input int i);
    return msb_m ? (w_m - 1 - i) : i;
  endfunction

  // SPI slave model: shifts sl_word out on miso and records mosi into sl_rx
  logic        sl_miso = 1'b0, sl_sck_p = 1'b0, sl_cs_p = 1'b0;
  logic [15:0] sl_rx = 16'h0000;
  int          sl_idx = 0;
  assign miso_s = loop_b ? mosi_m : sl_miso;

  always @(sck_m or cs_act) begin
    if (cs_act && !sl_cs_p) begin
      sl_idx  = 0;
      sl_rx   = 16'h0000;
      sl_miso = t_cpha ? 1'b0 : sl_word[bpos(0)];
    end else if (cs_act && (sck_m != sl_sck_p)) begin
      if (sck_m != t_cpol) begin
        if (t_cpha) begin
          if (sl_idx < w_m) sl_miso = sl_word[bpos(sl_idx)];
        end else begin
          if (sl_idx < w_m) sl_rx[bpos(sl_idx)] = mosi_m;
        end
      end else begin
        if (t_cpha) begin
          if (sl_idx < w_m) sl_rx[bpos(sl_idx)] = mosi_m;
          sl_idx++;
        end else begin
          sl_idx++;
          if (sl_idx < w_m) sl_miso = sl_word[bpos(sl_idx)];
        end
      end
    end
    sl_sck_p = sck_m;
    sl_cs_p  = cs_act;
  end

  // cycle monitor: busy cycles, leading edges, mosi changes off drive edges, CS errors
  int   busy_n = 0, lead_n = 0, mosi_bad_n = 0, cs_bad_n = 0, done_n = 0;
  logic pm_sck = 1'b0, pm_mosi = 1'b0, pm_busy = 1'b0;
  always @(negedge clk) begin
    if (busy_m) busy_n <= busy_n + 1;
    if (done_m) done_n <= done_n + 1;
    if (busy_m && (cs_m != exp_cs)) cs_bad_n <= cs_bad_n + 1;
    if (busy_m && pm_busy && (sck_m != pm_sck) && (sck_m != t_cpol)) lead_n <= lead_n + 1;
    if (busy_m && pm_busy && (mosi_m != pm_mosi) &&
        !((sck_m != pm_sck) && (t_cpha ? (sck_m != t_cpol) : (sck_m == t_cpol))))
      mosi_bad_n <= mosi_bad_n + 1;
    pm_sck  <= sck_m;
    pm_mosi <= mosi_m;
    pm_busy <= busy_m;
  end

  task automatic do_xfer(input string tag, input bit now, input logic cpol, input logic cpha,
                         input logic [2:0] sel, input logic [15:0] data, input logic [15:0] sword,
                         input bit loop, input bit mid);
    int b0, l0, m0, c0, cyc;
    logic [15:0] mask;
    if (!now) begin
      @(negedge clk);
      check_eq({tag, "_done_low"}, 32'(done_m), 32'd0);
    end
    mask    = (w_m == 16) ? 16'hFFFF : 16'h00FF;
    t_cpol  = cpol;
    t_cpha  = cpha;
    exp_cs  = ~(4'b0001 << sel);
    sl_word = sword & mask;
    loop_b  = loop;
    cpol_b  = cpol;
    cpha_b  = cpha;
    sel_b   = sel;
    din_b   = data;
    start_b = 1'b1;
    b0 = busy_n; l0 = lead_n; m0 = mosi_bad_n; c0 = cs_bad_n;
    @(negedge clk);
    start_b = 1'b0;
    cpol_b  = 1'($urandom);
    cpha_b  = 1'($urandom);
    sel_b   = 3'($urandom_range(0, 3));
    din_b   = 16'($urandom);
    check_eq({tag, "_busy_rise"}, 32'(busy_m), 32'd1);
    check_eq({tag, "_cs_on"}, 32'(cs_m), 32'(exp_cs));
    check_eq({tag, "_sck_idle"}, 32'(sck_m), 32'(cpol));
    cyc = 0;
    while (!done_m && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (mid && cyc == 4) begin
        start_b = 1'b1;
        din_b   = 16'hFFFF;
      end else begin
        start_b = 1'b0;
      end
    end
    check_eq({tag, "_done_seen"}, 32'(done_m), 32'd1);
    check_eq({tag, "_busy_len"}, 32'(busy_n - b0), 32'((2 * w_m + 2) * div_m));
    check_eq({tag, "_lead_edges"}, 32'(lead_n - l0), 32'(w_m));
    check_eq({tag, "_mosi_timing"}, 32'(mosi_bad_n - m0), 32'd0);
    check_eq({tag, "_cs_during"}, 32'(cs_bad_n - c0), 32'd0);
    check_eq({tag, "_dout"}, 32'(dout_m), 32'(loop ? (data & mask) : (sword & mask)));
    check_eq({tag, "_slave_rx"}, 32'(sl_rx), 32'(data & mask));
    check_eq({tag, "_cs_off"}, 32'(cs_m), 32'hF);
    check_eq({tag, "_busy_fall"}, 32'(busy_m), 32'd0);
    check_eq({tag, "_mosi_idle"}, 32'(mosi_m), 32'd0);
  endtask

  task automatic do_err(input logic [2:0] sel);
    @(negedge clk);
    sel_b   = sel;
    din_b   = 16'($urandom);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check_eq("err_pulse", 32'(err_m), 32'd1);
    check_eq("err_busy", 32'(busy_m), 32'd0);
    check_eq("err_cs", 32'(cs_m), 32'hF);
    @(negedge clk);
    check_eq("err_one_cycle", 32'(err_m), 32'd0);
    check_eq("err_busy_after", 32'(busy_m), 32'd0);
    check_eq("err_cs_after", 32'(cs_m), 32'hF);
  endtask

  task automatic do_rst_mid();
    int cyc, d0;
    @(negedge clk);
    t_cpol = 1'b0; t_cpha = 1'b0; exp_cs = 4'b1101; sl_word = 16'h005C; loop_b = 1'b0;
    cpol_b = 1'b0; cpha_b = 1'b0; sel_b = 3'd1; din_b = 16'h0096; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    while (sl_idx < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_reach_bit4", 32'(sl_idx), 32'd4);
    d0  = done_n;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_cs", 32'(cs_m), 32'hF);
    check_eq("rst_sck", 32'(sck_m), 32'd0);
    check_eq("rst_busy", 32'(busy_m), 32'd0);
    check_eq("rst_dout", 32'(dout_m), 32'd0);
    check_eq("rst_mosi", 32'(mosi_m), 32'd0);
    repeat (40) @(negedge clk);
    check_eq("rst_no_done", 32'(done_n - d0), 32'd0);
    check_eq("rst_still_idle", 32'(busy_m), 32'd0);
  endtask

  initial begin
    logic [15:0] rd, rw;
    logic        rc, rh, rl;
    logic [2:0]  rs;
    dsel = 0; rst = 1'b1; start_b = 1'b0; cpol_b = 1'b0; cpha_b = 1'b0;
    sel_b = 3'd0; din_b = 16'h0000;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      dsel = k;
      #1;
      check_eq($sformatf("reset%0d_busy", k), 32'(busy_m), 32'd0);
      check_eq($sformatf("reset%0d_done", k), 32'(done_m), 32'd0);
      check_eq($sformatf("reset%0d_err", k), 32'(err_m), 32'd0);
      check_eq($sformatf("reset%0d_cs", k), 32'(cs_m), 32'hF);
      check_eq($sformatf("reset%0d_sck", k), 32'(sck_m), 32'd0);
      check_eq($sformatf("reset%0d_mosi", k), 32'(mosi_m), 32'd0);
      check_eq($sformatf("reset%0d_dout", k), 32'(dout_m), 32'd0);
    end
    dsel = 0;
    rst  = 1'b0;

    do_xfer("a_m0_loop", 1'b0, 1'b0, 1'b0, 3'd0, 16'h00A5, 16'h0000, 1'b1, 1'b0);
    do_xfer("a_m3_slv", 1'b0, 1'b1, 1'b1, 3'd0, 16'h005A, 16'h003C, 1'b0, 1'b0);
    do_xfer("a_sel2", 1'b0, 1'b0, 1'b1, 3'd2, 16'h00D2, 16'h004B, 1'b0, 1'b0);
    do_err(3'd5);
    do_xfer("a_mid_start", 1'b0, 1'b0, 1'b0, 3'd1, 16'h0012, 16'h00C3, 1'b0, 1'b1);
    do_xfer("a_b2b_1", 1'b0, 1'b1, 1'b0, 3'd3, 16'h0081, 16'h0077, 1'b0, 1'b0);
    do_xfer("a_b2b_2", 1'b1, 1'b0, 1'b1, 3'd0, 16'h00E7, 16'h0019, 1'b1, 1'b0);
    do_rst_mid();
    for (int i = 0; i < 10; i++) begin
      rd = 16'($urandom); rw = 16'($urandom);
      rc = 1'($urandom); rh = 1'($urandom); rl = 1'($urandom);
      rs = 3'($urandom_range(0, 3));
      do_xfer($sformatf("a_rnd%0d", i), 1'b0, rc, rh, rs, rd, rw, rl, 1'b0);
    end

    @(negedge clk);
    dsel = 1;
    do_xfer("b_m1_loop", 1'b0, 1'b0, 1'b1, 3'd0, 16'hBEEF, 16'h0000, 1'b1, 1'b0);
    do_xfer("b_m3_lsb", 1'b0, 1'b1, 1'b1, 3'd0, 16'h1234, 16'h003C, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rd = 16'($urandom); rw = 16'($urandom);
      rc = 1'($urandom); rh = 1'($urandom); rl = 1'($urandom);
      do_xfer($sformatf("b_rnd%0d", i), 1'b0, rc, rh, 3'd0, rd, rw, rl, 1'b0);
    end
    @(negedge clk);
    check_eq("final_done_low", 32'(done_m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
